// File: rtl/rv32_pkg.sv
// ============================================================================
// Module   : rv32_pkg
// Purpose  : Shared load encodings, writeback FSM states and constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv32_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2,
        ST_FAULT    = 2'd3
    } wb_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic is_legal_load(input logic [2:0] funct3);
        return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
               (funct3 == LBU) || (funct3 == LHU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extender.sv
// ============================================================================
// Module   : load_extender
// Purpose  : Little-endian byte/halfword select with sign or zero extension.
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_extender
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (offset)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        ext = word;
        case (funct3)
            LB:      ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            LBU:     ext = {{(XLEN-8){1'b0}}, w_byte};
            LH:      ext = {{(XLEN-16){w_half[15]}}, w_half};
            LHU:     ext = {{(XLEN-16){1'b0}}, w_half};
            default: ext = word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// Module   : writeback_unit
// Purpose  : Register-file write driver merging ALU results and stalled loads.
//            Optional macro LOAD_MISALIGN_TRAP_EN traps misaligned LH/LHU/LW.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_unit
    import rv32_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ld_valid,
    input  logic [4:0]      ld_rd,
    input  logic [2:0]      ld_funct3,
    input  logic [XLEN-1:0] ld_addr,
    output logic            mem_read,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_busy,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] reg_write,
    output logic            stall,
    output logic            load_fault,
    output logic            misaligned
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       rd_q, rd_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic [XLEN-1:0]  w_ext;
    logic             w_illegal;
    logic             w_misalign;

    assign w_illegal = !is_legal_load(ld_funct3);

`ifdef LOAD_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign w_misalign = (((ld_funct3 == LH) || (ld_funct3 == LHU)) && ld_addr[0]) ||
                        ((ld_funct3 == LW) && (ld_addr[1:0] != 2'b00));
    assign misaligned = (state_q == ST_FAULT) && misalign_q;
`else
    assign w_misalign = 1'b0;
    assign misaligned = 1'b0;
`endif

    load_extender #(
        .XLEN (XLEN)
    ) u_ext (
        .funct3 (funct3_q),
        .offset (addr_q[1:0]),
        .word   (data_q),
        .ext    (w_ext)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_d     = rd_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        data_d   = data_q;
`ifdef LOAD_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ld_valid) begin
                    rd_d     = ld_rd;
                    funct3_d = ld_funct3;
                    addr_d   = ld_addr;
                    count_d  = '0;
                    if (w_illegal) begin
                        state_d = ST_FAULT;
                    end else if (w_misalign) begin
                        state_d = ST_FAULT;
`ifdef LOAD_MISALIGN_TRAP_EN
                        misalign_d = 1'b1;
`endif
                    end else begin
                        state_d = ST_WAIT_MEM;
                    end
                end
            end
            ST_WAIT_MEM: begin
                // Counter tracks busy cycles already spent; the last allowed one trips the timeout.
                if (!mem_busy) begin
                    data_d  = mem_rdata;
                    count_d = '0;
                    state_d = ST_WRITE;
                end else if (count_q == CNT_LAST) begin
                    count_d = '0;
                    state_d = ST_FAULT;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
`ifdef LOAD_MISALIGN_TRAP_EN
                misalign_d = 1'b0;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            rd_q     <= REG_ZERO;
            funct3_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
`ifdef LOAD_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
`ifdef LOAD_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    always_comb begin
        write      = 1'b0;
        rd         = REG_ZERO;
        reg_write  = '0;
        stall      = 1'b0;
        mem_read   = 1'b0;
        mem_addr   = '0;
        load_fault = 1'b0;
        case (state_q)
            ST_IDLE: begin
                write     = alu_valid && (alu_rd != REG_ZERO);
                rd        = alu_rd;
                reg_write = alu_result;
                stall     = ld_valid;
            end
            ST_WAIT_MEM: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[XLEN-1:2], 2'b00};
                stall    = 1'b1;
            end
            ST_WRITE: begin
                write     = (rd_q != REG_ZERO);
                rd        = rd_q;
                reg_write = w_ext;
            end
            ST_FAULT: begin
                load_fault = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
